// File: rtl/axi_lite_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi_lite_master_ctrl_if
// Purpose : AXI4-Lite channel bundle between the command sequencer (master)
//           and a memory-mapped slave.
// Ports   : AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// Params  : ADDR_W address width, DATA_W data width (strobe = DATA_W/8).
// ---------------------------------------------------------------------------
interface axi_lite_master_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_master_ctrl
// Purpose : Turns one armed LSU command (addr/data/sel/strobe/control) into a
//           single AXI4-Lite write or read and exports busy/done/err status.
// Ports   : i_clk, i_rst (sync, active-high)
//           i_axi_addr_reg, i_axi_data_reg, i_axi_sel_reg, i_axi_strobe_reg,
//           i_axi_control_reg (01 write, 10 read, 00/11 ignored)
//           axi            AXI4-Lite master modport
//           o_rx_data      last read data, held until the next read completes
//           o_busy/o_done/o_err  status
// Config  : define AXI_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES
//           wait cycles (dead-slave recovery).
// ---------------------------------------------------------------------------
module axi_lite_master_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_W-1:0]     i_axi_addr_reg,
  input  logic [DATA_W-1:0]     i_axi_data_reg,
  input  logic                  i_axi_sel_reg,
  input  logic [DATA_W/8-1:0]   i_axi_strobe_reg,
  input  logic [1:0]            i_axi_control_reg,
  axi_lite_master_ctrl_if.master axi,
  output logic [DATA_W-1:0]     o_rx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam logic [1:0]  CTRL_WRITE = 2'b01;
  localparam logic [1:0]  CTRL_READ  = 2'b10;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  // The wait counter is 16 bits wide, so the limit must fit.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_DONE, S_REARM
  } state_t;

  state_t            state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
`ifdef AXI_TIMEOUT_EN
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              timeout_c;
`endif

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rx_data_q <= '0;
`ifdef AXI_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rx_data_q <= rx_data_d;
`ifdef AXI_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rx_data_d = rx_data_q;
`ifdef AXI_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_c  = 1'b0;
    if (state_q inside {S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R}) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
      // Compare against limit-1 so the abort edge is the TIMEOUT_CYCLES-th wait cycle
      timeout_c  = (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (i_axi_sel_reg && i_axi_control_reg == CTRL_WRITE) begin
          state_d   = S_WR_AW_W;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = i_axi_addr_reg;
          wdata_d   = i_axi_data_reg;
          wstrb_d   = i_axi_strobe_reg;
          err_d     = 1'b0;
`ifdef AXI_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else if (i_axi_sel_reg && i_axi_control_reg == CTRL_READ) begin
          state_d   = S_RD_AR;
          arvalid_d = 1'b1;
          araddr_d  = i_axi_addr_reg;
          err_d     = 1'b0;
`ifdef AXI_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      S_WR_AW_W: begin
        // AW and W complete independently; leave only once both are done
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WR_B;
          bready_d = 1'b1;
        end
      end
      S_WR_B: begin
        if (axi.bvalid) begin
          err_d    = (axi.bresp != RESP_OKAY);
          bready_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_RD_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (axi.rvalid) begin
          rx_data_d = axi.rdata;
          err_d     = (axi.rresp != RESP_OKAY);
          rready_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_REARM;
      S_REARM: if (!i_axi_sel_reg) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_TIMEOUT_EN
    // Dead-slave abort: drop every valid/ready and report an error
    if (timeout_c) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      err_d     = 1'b1;
      done_d    = 1'b1;
      state_d   = S_DONE;
    end
`endif

    busy_d = !(state_d inside {S_IDLE, S_REARM});
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign o_rx_data   = rx_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
endmodule
